mvu_thresh_stream: RTL and testbench
====================================

// Module: mvu_thresh_stream
// PURPOSE
//  Multi-threshold activation stage placed directly downstream of mvu_stream.
//  Consumes PE packed accumulator outputs (TDstI bits each) via valid/ready, and
//  compares each against that output channel's NThres thresholds. Emits
//  PE packed quantized activations (TOut bits each) to the next layer's input.
//  Tracks neuron fold (nf) internally: successive input beats cover channels
//  nf*PE .. nf*PE+PE-1.
// PARAMETERS
//  PE      2  accumulators per beat (matches upstream PE)
//  NF      1  neuron folds = MatrixH/PE; nf counter range 0..NF-1
//  TDstI   8  accumulator and threshold bit width
//  NThres  15 thresholds per channel
//  TOut    4  output width; must equal $clog2(NThres+1)
//  OP_SGN  0  1: signed compare of acc vs thresholds; 0: unsigned
//  THR_AW  derived = $clog2(NF*PE*NThres) (min 1); threshold write address width
// PORTS
//  clock     in   1            rising-edge clock
//  reset     in   1            asynchronous, active-high reset
//  in_v      in   1            accumulator beat valid (from mvu_stream out_v)
//  wready    out  1            beat accepted when in_v & wready
//  in_acc    in   PE*TDstI     PE p at [p*TDstI +: TDstI]
//  out_v     out  1            activation beat valid
//  rready    in   1            downstream ready
//  out       out  PE*TOut      PE p at [p*TOut +: TOut]
//  thr_we    in   1            threshold write strobe
//  thr_addr  in   THR_AW       flat index ((nf*PE)+pe)*NThres+idx
//  thr_data  in   TDstI        threshold value
// BEHAVIOUR
//  - Reset: wready=0 during reset, then 1 once the pipeline is empty; out_v=0, out=0.
//    nf_cnt=0; stage valids=0. Threshold storage is NOT reset (keeps contents).
//  - Pipeline: S1 registers in_acc and nf_cnt and reads thresholds[nf_cnt];
//    S2 compares and registers out. Accept at edge t -> out_v=1 after edge t+1.
//  - Stall: s2_en = ~out_v | rready; s1_en = ~s1_v | s2_en; wready = s1_en.
//    While out_v & ~rready, out and out_v hold stable (AXI-stream rules).
//    Full throughput: 1 beat/cycle when rready held high.
//  - out[p] = count of i in 0..NThres-1 where acc[p] >= thr[nf][p][i]. Compare is
//    signed if OP_SGN, else unsigned. Ascending thresholds are not required.
//    Result is saturated to 2**TOut-1.
//  - nf_cnt increments on each accepted beat and wraps NF-1 -> 0 (NF=1: stays 0).
//  - Threshold write: takes effect at the next edge. A simultaneous S1 read of the
//    same entry returns the OLD value (read-first). thr_addr >= NF*PE*NThres is ignored.
//  - Boundaries:
//    - acc equal to a threshold counts as >= .
//    - All thresholds above acc -> 0.
//    - All thresholds at or below acc -> NThres.
//    - Reset mid-stream drops in-flight beats and restarts nf at 0.
// CONFIGURATION
//  MVU_THRESH_BIAS_EN defined: adds parameter ActBias (default 0, signed TOut+1 bits).
//    out[p] = clamp(count+ActBias, 0, 2**TOut-1); arithmetic is done in TOut+2 bits.
//    This adds one extra output-register stage, so latency becomes 3.
//  MVU_THRESH_BIAS_EN undefined: no bias logic; latency 2.
// STRUCTURE
//  Package mvu_thresh_pkg holds:
//    - acc_t/thr_t typedefs
//    - function thr_count(acc, thr_vec, sgn)
//    - function clog2_min1
//  Sub-module mvu_thresh_mem holds the register array [NF][PE][NThres]:
//    - single write port
//    - registered full-row read indexed by nf
//    - read-first on collision
// TESTING
//  T1 PE=2,NF=1,NThres=3,TOut=2, thr={2,5,9} both PE; acc {5,1}, rready=1 -> out {2,0} two cycles after accept
//  T2 NF=2: per-fold thresholds {0,0,0} / {100,100,100}; beats acc=50 x4 -> out 3,0,3,0 (nf wrap)
//  T3 rready=0 for 5 cycles while streaming -> wready drops after 2 beats held; out stable; no beat lost/duplicated
//  T4 OP_SGN=1, TDstI=8, thr={-128,-1,0}; acc=-1 -> 2; acc=0x80 -> 1; OP_SGN=0 acc=0x80 vs thr={0x7F,0x80,0xFF} -> 2
//  T5 thr_we to entry being read in the same cycle -> old value used; next beat uses new value
//  T6 assert reset with 2 beats in flight -> out_v=0 immediately; after release first beat uses nf=0 thresholds

Source files
------------

// File: rtl/mvu_thresh_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mvu_thresh_pkg
// Brief    : Shared types and helpers for the multi-threshold activation stage.
// Revision : 1.0 - initial release
// ============================================================================
package mvu_thresh_pkg;

    localparam int c_MAX_W     = 32;
    localparam int c_MAX_THRES = 64;

    typedef logic [c_MAX_W-1:0] acc_t;
    typedef logic [c_MAX_W-1:0] thr_t;
    typedef logic [c_MAX_THRES-1:0][c_MAX_W-1:0] thr_vec_t;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Operands arrive already sign- or zero-extended to c_MAX_W bits.
    function automatic logic [7:0] thr_count(input acc_t acc, input thr_vec_t thr_vec,
                                             input int n, input logic sgn);
        logic [7:0] cnt;
        logic       ge;
        cnt = '0;
        for (int i = 0; i < c_MAX_THRES; i++) begin
            if (i < n) begin
                ge = sgn ? ($signed(acc) >= $signed(thr_vec[i])) : (acc >= thr_vec[i]);
                if (ge) cnt = cnt + 8'd1;
            end
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mvu_thresh_mem.sv
`default_nettype none
// ============================================================================
// Module   : mvu_thresh_mem
// Brief    : Threshold register array with one write port and a registered
//            full-row read per neuron fold (read-first on collision).
// Revision : 1.0 - initial release
// ============================================================================
module mvu_thresh_mem
    import mvu_thresh_pkg::*;
#(
    parameter int PE     = 2,
    parameter int NF     = 1,
    parameter int TDstI  = 8,
    parameter int NThres = 15,
    parameter int THR_AW = clog2_min1(NF*PE*NThres),
    parameter int NF_W   = clog2_min1(NF)
)(
    input  logic                        clock,
    input  logic                        thr_we,
    input  logic [THR_AW-1:0]           thr_addr,
    input  logic [TDstI-1:0]            thr_data,
    input  logic                        rd_en,
    input  logic [NF_W-1:0]             rd_nf,
    output logic [PE*NThres*TDstI-1:0]  rd_row
);

    localparam int c_ROW   = PE*NThres;
    localparam int c_DEPTH = NF*c_ROW;

    logic [TDstI-1:0]           r_mem [c_DEPTH];
    logic [PE*NThres*TDstI-1:0] r_row;

    // Storage deliberately has no reset so thresholds survive a pipeline flush.
    always_ff @(posedge clock) begin
        if (thr_we && (32'(thr_addr) < c_DEPTH)) begin
            r_mem[thr_addr] <= thr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rd_en) begin
            for (int j = 0; j < c_ROW; j++) begin
                r_row[j*TDstI +: TDstI] <= r_mem[THR_AW'(int'(rd_nf) * c_ROW + j)];
            end
        end
    end

    assign rd_row = r_row;

endmodule
`default_nettype wire

// File: rtl/mvu_thresh_stream.sv
`default_nettype none
// ============================================================================
// Module   : mvu_thresh_stream
// Brief    : Streaming multi-threshold activation after mvu_stream. Optional
//            output bias stage enabled by defining MVU_THRESH_BIAS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mvu_thresh_stream
    import mvu_thresh_pkg::*;
#(
    parameter int PE     = 2,
    parameter int NF     = 1,
    parameter int TDstI  = 8,
    parameter int NThres = 15,
    parameter int TOut   = 4,
    parameter int OP_SGN = 0,
`ifdef MVU_THRESH_BIAS_EN
    parameter logic signed [TOut:0] ActBias = '0,
`endif
    parameter int THR_AW = clog2_min1(NF*PE*NThres)
)(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_v,
    output logic                 wready,
    input  logic [PE*TDstI-1:0]  in_acc,
    output logic                 out_v,
    input  logic                 rready,
    output logic [PE*TOut-1:0]   out,
    input  logic                 thr_we,
    input  logic [THR_AW-1:0]    thr_addr,
    input  logic [TDstI-1:0]     thr_data
);

    localparam int c_NF_W    = clog2_min1(NF);
    localparam int c_OUT_MAX = (1 << TOut) - 1;

    logic                       r_live;
    logic                       r_s1_v;
    logic                       r_out_v;
    logic [c_NF_W-1:0]          r_nf;
    logic [PE*TDstI-1:0]        r_s1_acc;
    logic [PE*TOut-1:0]         r_out;
    logic [PE*NThres*TDstI-1:0] w_row;
    logic [PE*TOut-1:0]         w_cnt;
    logic                       w_s1_en;
    logic                       w_s2_en;
    logic                       w_take;

`ifdef MVU_THRESH_BIAS_EN
    logic                       r_s2_v;
    logic [PE*TOut-1:0]         r_s2_cnt;
    logic [PE*TOut-1:0]         w_biased;
    logic                       w_out_en;

    assign w_out_en = ~r_out_v | rready;
    assign w_s2_en  = ~r_s2_v | w_out_en;
`else
    assign w_s2_en  = ~r_out_v | rready;
`endif
    assign w_s1_en = ~r_s1_v | w_s2_en;
    // r_live keeps wready low through reset and the first edge after it.
    assign wready  = w_s1_en & r_live;
    assign w_take  = in_v & wready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_live   <= 1'b0;
            r_s1_v   <= 1'b0;
            r_nf     <= '0;
            r_s1_acc <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_s1_en) r_s1_v <= w_take;
            if (w_take) begin
                r_s1_acc <= in_acc;
                r_nf     <= (r_nf == c_NF_W'(NF-1)) ? '0 : r_nf + 1'b1;
            end
        end
    end

    mvu_thresh_mem #(
        .PE     (PE),
        .NF     (NF),
        .TDstI  (TDstI),
        .NThres (NThres),
        .THR_AW (THR_AW),
        .NF_W   (c_NF_W)
    ) u_mem (
        .clock    (clock),
        .thr_we   (thr_we),
        .thr_addr (thr_addr),
        .thr_data (thr_data),
        .rd_en    (w_take),
        .rd_nf    (r_nf),
        .rd_row   (w_row)
    );

    for (genvar p = 0; p < PE; p++) begin : g_pe
        acc_t            w_acc;
        thr_vec_t        w_thr;
        logic [7:0]      w_n;
        logic [TOut-1:0] w_sat;

        always_comb begin
            w_acc = (OP_SGN != 0) ? acc_t'($signed(r_s1_acc[p*TDstI +: TDstI]))
                                  : acc_t'(r_s1_acc[p*TDstI +: TDstI]);
            w_thr = '0;
            for (int i = 0; i < NThres; i++) begin
                w_thr[i] = (OP_SGN != 0) ? thr_t'($signed(w_row[(p*NThres+i)*TDstI +: TDstI]))
                                         : thr_t'(w_row[(p*NThres+i)*TDstI +: TDstI]);
            end
            w_n   = thr_count(w_acc, w_thr, NThres, OP_SGN != 0);
            w_sat = (int'(w_n) > c_OUT_MAX) ? TOut'(c_OUT_MAX) : w_n[TOut-1:0];
        end

        assign w_cnt[p*TOut +: TOut] = w_sat;
    end

`ifdef MVU_THRESH_BIAS_EN
    for (genvar p = 0; p < PE; p++) begin : g_bias
        logic signed [TOut+1:0] w_sum;

        assign w_sum = $signed({2'b00, r_s2_cnt[p*TOut +: TOut]}) + ActBias;
        assign w_biased[p*TOut +: TOut] =
            w_sum[TOut+1]                              ? '0 :
            (w_sum > $signed((TOut+2)'(c_OUT_MAX)))    ? TOut'(c_OUT_MAX) :
                                                         w_sum[TOut-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s2_v   <= 1'b0;
            r_s2_cnt <= '0;
            r_out_v  <= 1'b0;
            r_out    <= '0;
        end else begin
            if (w_s2_en) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) r_s2_cnt <= w_cnt;
            end
            if (w_out_en) begin
                r_out_v <= r_s2_v;
                if (r_s2_v) r_out <= w_biased;
            end
        end
    end
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_v <= 1'b0;
            r_out   <= '0;
        end else if (w_s2_en) begin
            r_out_v <= r_s1_v;
            if (r_s1_v) r_out <= w_cnt;
        end
    end
`endif

    assign out_v = r_out_v;
    assign out   = r_out;

endmodule
`default_nettype wire

// File: tb/tb_mvu_thresh_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvu_thresh_stream
// Brief    : Directed self-checking bench for mvu_thresh_stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mvu_thresh_stream;

`ifdef MVU_THRESH_BIAS_EN
    localparam int c_LAT = 3;
`else
    localparam int c_LAT = 2;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Instance A: unsigned, two folds.  Instance B: signed, one fold.
    logic        a_in_v, a_wready, a_out_v, a_rready, a_thr_we;
    logic [15:0] a_in_acc;
    logic [3:0]  a_out, a_thr_addr;
    logic [7:0]  a_thr_data;
    logic        b_in_v, b_wready, b_out_v, b_rready, b_thr_we;
    logic [15:0] b_in_acc;
    logic [3:0]  b_out;
    logic [2:0]  b_thr_addr;
    logic [7:0]  b_thr_data;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] stim0 [8];
    logic [7:0] stim1 [8];
    logic [3:0] expv  [8];

    mvu_thresh_stream #(.PE(2), .NF(2), .TDstI(8), .NThres(3), .TOut(2), .OP_SGN(0)) u_dut_a (
        .clock(clock), .reset(reset), .in_v(a_in_v), .wready(a_wready), .in_acc(a_in_acc),
        .out_v(a_out_v), .rready(a_rready), .out(a_out),
        .thr_we(a_thr_we), .thr_addr(a_thr_addr), .thr_data(a_thr_data)
    );

    mvu_thresh_stream #(.PE(2), .NF(1), .TDstI(8), .NThres(3), .TOut(2), .OP_SGN(1)) u_dut_b (
        .clock(clock), .reset(reset), .in_v(b_in_v), .wready(b_wready), .in_acc(b_in_acc),
        .out_v(b_out_v), .rready(b_rready), .out(b_out),
        .thr_we(b_thr_we), .thr_addr(b_thr_addr), .thr_data(b_thr_data)
    );

    task automatic do_reset();
        reset = 1'b1;
        a_in_v = 1'b0; b_in_v = 1'b0; a_thr_we = 1'b0; b_thr_we = 1'b0;
        a_rready = 1'b1; b_rready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic write_thr_a(input logic [3:0] addr, input logic [7:0] data);
        a_thr_we = 1'b1; a_thr_addr = addr; a_thr_data = data;
        @(posedge clock); #1;
        a_thr_we = 1'b0;
    endtask

    task automatic set_fold_a(input int nf, input logic [7:0] t0, input logic [7:0] t1,
                              input logic [7:0] t2);
        logic [7:0] tv [3];
        tv[0] = t0; tv[1] = t1; tv[2] = t2;
        for (int pe = 0; pe < 2; pe++)
            for (int i = 0; i < 3; i++)
                write_thr_a(4'((nf*2 + pe)*3 + i), tv[i]);
    endtask

    task automatic write_thr_b(input logic [2:0] addr, input logic [7:0] data);
        b_thr_we = 1'b1; b_thr_addr = addr; b_thr_data = data;
        @(posedge clock); #1;
        b_thr_we = 1'b0;
    endtask

    // Presents stim0/stim1 beats on instance A, each held until accepted.
    task automatic drive_beats(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            a_in_v = 1'b1; a_in_acc = {stim1[i], stim0[i]};
            w = 0;
            @(negedge clock);
            while (!a_wready && w < 50) begin @(negedge clock); w++; end
            n_cmp++;
            if (!a_wready) begin
                n_fail++;
                $display("FAIL drive_accept[%0d]: got wready=%b, want 1 within 50 cycles", i, a_wready);
            end
            @(posedge clock); #1;
        end
        a_in_v = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_cmp++; if (a_wready !== 1'b0) begin n_fail++; $display("FAIL rst_wready: got %b want 0", a_wready); end
        n_cmp++; if (a_out_v !== 1'b0) begin n_fail++; $display("FAIL rst_out_v: got %b want 0", a_out_v); end
        n_cmp++; if (a_out !== 4'h0) begin n_fail++; $display("FAIL rst_out: got %h want 0", a_out); end
        n_cmp++; if (b_out_v !== 1'b0) begin n_fail++; $display("FAIL rst_b_out_v: got %b want 0", b_out_v); end
        @(posedge clock); #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_cmp++; if (a_wready !== 1'b1) begin n_fail++; $display("FAIL post_rst_wready: got %b want 1", a_wready); end
        n_cmp++; if (b_wready !== 1'b1) begin n_fail++; $display("FAIL post_rst_b_wready: got %b want 1", b_wready); end
        n_cmp++; if (a_out_v !== 1'b0) begin n_fail++; $display("FAIL post_rst_out_v: got %b want 0", a_out_v); end
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        int lat;
        int w;
        do_reset();
        set_fold_a(0, 8'd2, 8'd5, 8'd9);
        set_fold_a(1, 8'd2, 8'd5, 8'd9);
        a_in_v = 1'b1; a_in_acc = {8'd1, 8'd5};
        @(negedge clock);
        n_cmp++; if (a_wready !== 1'b1) begin n_fail++; $display("FAIL t1_wready: got %b want 1", a_wready); end
        @(posedge clock); #1 a_in_v = 1'b0;
        lat = 1;
        @(negedge clock);
        while (!a_out_v && lat < 20) begin @(negedge clock); lat++; end
        n_cmp++; if (lat != c_LAT) begin n_fail++; $display("FAIL t1_latency: got %0d want %0d", lat, c_LAT); end
        n_cmp++; if (a_out !== 4'h2) begin n_fail++; $display("FAIL t1_out: got %h want 2", a_out); end
        @(posedge clock); #1;
        stim0[0] = 8'd9;   stim1[0] = 8'd2; expv[0] = 4'h7;
        stim0[1] = 8'd255; stim1[1] = 8'd0; expv[1] = 4'h3;
        stim0[2] = 8'd4;   stim1[2] = 8'd5; expv[2] = 4'h9;
        fork
            drive_beats(3);
            for (int k = 0; k < 3; k++) begin
                w = 0;
                @(negedge clock);
                while (!(a_out_v && a_rready) && w < 40) begin @(negedge clock); w++; end
                n_cmp++;
                if (!a_out_v || a_out !== expv[k]) begin
                    n_fail++;
                    $display("FAIL t1_stream[%0d]: got v=%b out=%h want v=1 out=%h", k, a_out_v, a_out, expv[k]);
                end
            end
        join
        @(posedge clock); #1;
    endtask

    task automatic test_nf_wrap();
        int w;
        do_reset();
        set_fold_a(0, 8'd0, 8'd0, 8'd0);
        set_fold_a(1, 8'd100, 8'd100, 8'd100);
        for (int i = 0; i < 4; i++) begin
            stim0[i] = 8'd50; stim1[i] = 8'd50;
            expv[i] = (i % 2 == 0) ? 4'hF : 4'h0;
        end
        fork
            drive_beats(4);
            for (int k = 0; k < 4; k++) begin
                w = 0;
                @(negedge clock);
                while (!(a_out_v && a_rready) && w < 40) begin @(negedge clock); w++; end
                n_cmp++;
                if (!a_out_v || a_out !== expv[k]) begin
                    n_fail++;
                    $display("FAIL t2_nf[%0d]: got v=%b out=%h want v=1 out=%h", k, a_out_v, a_out, expv[k]);
                end
            end
        join
        @(posedge clock); #1;
    endtask

    task automatic test_backpressure();
        int w;
        do_reset();
        set_fold_a(0, 8'd10, 8'd20, 8'd30);
        set_fold_a(1, 8'd10, 8'd20, 8'd30);
        stim0[0] = 8'd5;  stim1[0] = 8'd35; expv[0] = 4'hC;
        stim0[1] = 8'd15; stim1[1] = 8'd25; expv[1] = 4'h9;
        stim0[2] = 8'd25; stim1[2] = 8'd15; expv[2] = 4'h6;
        stim0[3] = 8'd35; stim1[3] = 8'd5;  expv[3] = 4'h3;
        stim0[4] = 8'd0;  stim1[4] = 8'd30; expv[4] = 4'hC;
        stim0[5] = 8'd12; stim1[5] = 8'd20; expv[5] = 4'h9;
        a_rready = 1'b0;
        fork
            drive_beats(6);
            begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clock);
                    if (c >= 3) begin
                        n_cmp++;
                        if (a_wready !== 1'b0) begin
                            n_fail++; $display("FAIL t3_wready_stall[%0d]: got %b want 0", c, a_wready);
                        end
                        n_cmp++;
                        if (a_out_v !== 1'b1 || a_out !== 4'hC) begin
                            n_fail++; $display("FAIL t3_hold[%0d]: got v=%b out=%h want v=1 out=c", c, a_out_v, a_out);
                        end
                    end
                end
                @(posedge clock); #1 a_rready = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    w = 0;
                    @(negedge clock);
                    while (!(a_out_v && a_rready) && w < 40) begin @(negedge clock); w++; end
                    n_cmp++;
                    if (!a_out_v || a_out !== expv[k]) begin
                        n_fail++;
                        $display("FAIL t3_stream[%0d]: got v=%b out=%h want v=1 out=%h", k, a_out_v, a_out, expv[k]);
                    end
                end
            end
        join
        @(posedge clock); #1;
    endtask

    task automatic test_compare_modes();
        int w;
        logic [15:0] bacc [3];
        logic [3:0]  bexp [3];
        do_reset();
        set_fold_a(0, 8'h7F, 8'h80, 8'hFF);
        set_fold_a(1, 8'h7F, 8'h80, 8'hFF);
        stim0[0] = 8'h80; stim1[0] = 8'hFF; expv[0] = 4'hE;
        stim0[1] = 8'h7E; stim1[1] = 8'h7F; expv[1] = 4'h4;
        fork
            drive_beats(2);
            for (int k = 0; k < 2; k++) begin
                w = 0;
                @(negedge clock);
                while (!(a_out_v && a_rready) && w < 40) begin @(negedge clock); w++; end
                n_cmp++;
                if (!a_out_v || a_out !== expv[k]) begin
                    n_fail++;
                    $display("FAIL t4_unsigned[%0d]: got v=%b out=%h want v=1 out=%h", k, a_out_v, a_out, expv[k]);
                end
            end
        join
        @(posedge clock); #1;
        for (int pe = 0; pe < 2; pe++) begin
            write_thr_b(3'(pe*3 + 0), 8'h80);
            write_thr_b(3'(pe*3 + 1), 8'hFF);
            write_thr_b(3'(pe*3 + 2), 8'h00);
        end
        bacc[0] = {8'h80, 8'hFF}; bexp[0] = 4'h6;
        bacc[1] = {8'h7F, 8'h00}; bexp[1] = 4'hF;
        bacc[2] = {8'hFE, 8'h81}; bexp[2] = 4'h5;
        for (int k = 0; k < 3; k++) begin
            b_in_v = 1'b1; b_in_acc = bacc[k];
            @(negedge clock);
            n_cmp++; if (b_wready !== 1'b1) begin n_fail++; $display("FAIL t4_b_wready[%0d]: got %b want 1", k, b_wready); end
            @(posedge clock); #1 b_in_v = 1'b0;
            w = 0;
            @(negedge clock);
            while (!b_out_v && w < 20) begin @(negedge clock); w++; end
            n_cmp++;
            if (!b_out_v || b_out !== bexp[k]) begin
                n_fail++;
                $display("FAIL t4_signed[%0d]: got v=%b out=%h want v=1 out=%h", k, b_out_v, b_out, bexp[k]);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_read_first();
        int w;
        do_reset();
        set_fold_a(0, 8'd10, 8'd10, 8'd10);
        set_fold_a(1, 8'd200, 8'd200, 8'd200);
        a_in_v = 1'b1; a_in_acc = {8'd10, 8'd10};
        a_thr_we = 1'b1; a_thr_addr = 4'd2; a_thr_data = 8'd50;
        @(negedge clock);
        n_cmp++; if (a_wready !== 1'b1) begin n_fail++; $display("FAIL t5_wready: got %b want 1", a_wready); end
        @(posedge clock); #1 a_in_v = 1'b0; a_thr_we = 1'b0;
        w = 0;
        @(negedge clock);
        while (!a_out_v && w < 20) begin @(negedge clock); w++; end
        n_cmp++;
        if (!a_out_v || a_out !== 4'hF) begin
            n_fail++; $display("FAIL t5_old_value: got v=%b out=%h want v=1 out=f", a_out_v, a_out);
        end
        @(posedge clock); #1;
        stim0[0] = 8'd10; stim1[0] = 8'd10; expv[0] = 4'h0;
        stim0[1] = 8'd10; stim1[1] = 8'd10; expv[1] = 4'hE;
        fork
            drive_beats(2);
            for (int k = 0; k < 2; k++) begin
                w = 0;
                @(negedge clock);
                while (!(a_out_v && a_rready) && w < 40) begin @(negedge clock); w++; end
                n_cmp++;
                if (!a_out_v || a_out !== expv[k]) begin
                    n_fail++;
                    $display("FAIL t5_new_value[%0d]: got v=%b out=%h want v=1 out=%h", k, a_out_v, a_out, expv[k]);
                end
            end
        join
        @(posedge clock); #1;
    endtask

    task automatic test_reset_midstream();
        int w;
        int seen;
        do_reset();
        set_fold_a(0, 8'd0, 8'd0, 8'd0);
        set_fold_a(1, 8'd100, 8'd100, 8'd100);
        for (int i = 0; i < 3; i++) begin stim0[i] = 8'd50; stim1[i] = 8'd50; end
        drive_beats(3);
        reset = 1'b1;
        #1;
        n_cmp++; if (a_out_v !== 1'b0) begin n_fail++; $display("FAIL t6_out_v: got %b want 0", a_out_v); end
        n_cmp++; if (a_out !== 4'h0) begin n_fail++; $display("FAIL t6_out: got %h want 0", a_out); end
        n_cmp++; if (a_wready !== 1'b0) begin n_fail++; $display("FAIL t6_wready: got %b want 0", a_wready); end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (a_out_v) seen++;
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL t6_dropped: got %0d stale beats want 0", seen); end
        @(posedge clock); #1;
        stim0[0] = 8'd50; stim1[0] = 8'd50; expv[0] = 4'hF;
        fork
            drive_beats(1);
            begin
                w = 0;
                @(negedge clock);
                while (!(a_out_v && a_rready) && w < 40) begin @(negedge clock); w++; end
                n_cmp++;
                if (!a_out_v || a_out !== expv[0]) begin
                    n_fail++; $display("FAIL t6_restart_nf: got v=%b out=%h want v=1 out=%h", a_out_v, a_out, expv[0]);
                end
            end
        join
        @(posedge clock); #1;
    endtask

    initial begin
        a_in_v = 1'b0; a_in_acc = '0; a_rready = 1'b1; a_thr_we = 1'b0; a_thr_addr = '0; a_thr_data = '0;
        b_in_v = 1'b0; b_in_acc = '0; b_rready = 1'b1; b_thr_we = 1'b0; b_thr_addr = '0; b_thr_data = '0;
        test_reset();
        test_basic();
        test_nf_wrap();
        test_backpressure();
        test_compare_modes();
        test_read_first();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
